crc8_serial: RTL and testbench
==============================

CRC8_SERIAL -- requirements
Module: crc8_serial

Interface
REQ-001 The block SHALL have parameter POLY, default 8'h07, meaning the CRC-8 generator polynomial without the implicit x^8 term.
REQ-002 The block SHALL have parameter INIT, default 8'h00, meaning the running-CRC value loaded at reset, at clear and at the start of each message.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port clear, input, 1 bit: synchronous abort; the running CRC returns to INIT.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data and in_last are valid.
REQ-007 The block SHALL have port in_data, input, 8 bits: message byte, processed MSB first.
REQ-008 The block SHALL have port in_last, input, 1 bit: the accompanying byte ends the message.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-010 The block SHALL have port crc_valid, output, 1 bit: one-cycle pulse marking crc_out as a new message result.
REQ-011 The block SHALL have port crc_out, output, 8 bits: CRC of the last completed message, held until the next completion.
REQ-012 The block SHALL have port busy, output, 1 bit: high while not in IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL equal (state==IDLE) && !clear.
REQ-015 A byte SHALL be accepted when in_valid && in_ready; it is then latched into a shift register, in_last is latched, the 3-bit bit counter is set to 0, and the FSM goes to SHIFT.
REQ-016 In SHIFT, one bit per cycle SHALL be processed MSB first: fb = crc[7] XOR d; crc <= {crc[6:0],0} XOR (fb ? POLY : 0).
REQ-017 SHIFT SHALL last exactly 8 cycles; on the 8th cycle (counter==7) the FSM goes to DONE if the latched last is set, otherwise to IDLE.
REQ-018 In DONE, crc_valid SHALL be 1 for exactly one cycle, crc_out SHALL update to the final value, the running CRC SHALL reload INIT, and the FSM SHALL return to IDLE.
REQ-019 Latency SHALL be as follows: for a byte accepted in cycle T, in_ready is high again in T+9 (non-last); for a last byte, crc_valid is high in T+9 and in_ready is high in T+10.
REQ-020 The maximum throughput SHALL be one byte per 9 cycles (non-last) or 10 cycles (last).
REQ-021 clear SHALL take effect in any state and have priority over in_valid and over DONE: the FSM goes to IDLE, the running CRC to INIT, there is no crc_valid pulse, and crc_out is unchanged.
REQ-022 in_data and in_last SHALL be ignored while in_ready is low; no buffering.
REQ-023 A single-byte message (in_last with the first byte) SHALL be legal.
REQ-024 No data-dependent stall SHALL occur; the arithmetic is modulo 2, 8 bits wide, with no carries.

Reset
REQ-025 While rst_n is low, the outputs SHALL be: state IDLE, crc_out=8'h00, crc_valid=0, busy=0, in_ready=1 (when clear=0), running CRC=INIT, counter=0.
REQ-026 Reset mid-message SHALL discard the partial CRC without any crc_valid pulse.

Configuration
REQ-027 The macro CRC8_SERIAL_XOROUT_EN SHALL control the output XOR: when defined, crc_out is loaded with final CRC XOR 8'hFF; when undefined, crc_out is loaded with the final CRC unmodified; all other behaviour is identical.

Verification
REQ-028 Bench scenario, macro undefined, defaults: send single byte 8'h01 with last -> crc_valid pulse at T+9, crc_out=8'h07.
REQ-029 Bench scenario: send ASCII "123456789" (9 bytes, last on '9') -> crc_out=8'hF4; with CRC8_SERIAL_XOROUT_EN -> 8'h0B.
REQ-030 Bench scenario: single byte 8'hFF with last -> crc_out=8'hF3; then single byte 8'h00 with last -> crc_out=8'h00 (INIT reload verified).
REQ-031 Bench scenario: in_valid held high continuously -> in_ready high only in IDLE, one accept per 9 or 10 cycles, busy asserted throughout SHIFT and DONE.
REQ-032 Bench scenario: clear asserted during SHIFT of byte 3 of "123456789", then the full message resent -> no intermediate crc_valid, final crc_out=8'hF4.
REQ-033 Bench scenario: rst_n pulsed low asynchronously mid-SHIFT -> immediate IDLE, crc_out=8'h00, no crc_valid.

Source files
------------

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 engine: one message bit per clock, MSB first, IDLE/SHIFT/DONE FSM.
// Define CRC8_SERIAL_XOROUT_EN to invert the final CRC (XOR 8'hFF) on its way to crc_out.
module crc8_serial #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       crc_valid,
  output logic [7:0] crc_out,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state_q;
  logic [7:0] sh_q;
  logic [7:0] crc_q;
  logic [7:0] crc_out_q;
  logic       last_q;
  logic       crc_valid_q;
  logic [2:0] cnt_q;

  logic       fb;
  logic [7:0] crc_d;
  logic [7:0] crc_fin;

  assign fb    = crc_q[7] ^ sh_q[7];
  assign crc_d = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);

`ifdef CRC8_SERIAL_XOROUT_EN
  assign crc_fin = crc_d ^ 8'hFF;
`else
  assign crc_fin = crc_d;
`endif

  assign in_ready  = (state_q == IDLE) && !clear;
  assign busy      = (state_q != IDLE);
  assign crc_valid = crc_valid_q;
  assign crc_out   = crc_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= 8'h00;
      crc_q       <= INIT;
      crc_out_q   <= 8'h00;
      last_q      <= 1'b0;
      crc_valid_q <= 1'b0;
      cnt_q       <= 3'd0;
    end else begin
      crc_valid_q <= 1'b0;
      if (clear) begin
        // Abort wins over everything, including the hand-off into DONE.
        state_q <= IDLE;
        crc_q   <= INIT;
        cnt_q   <= 3'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_valid) begin
              sh_q    <= in_data;
              last_q  <= in_last;
              cnt_q   <= 3'd0;
              state_q <= SHIFT;
            end
          end
          SHIFT: begin
            crc_q <= crc_d;
            sh_q  <= {sh_q[6:0], 1'b0};
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (last_q) begin
                // Result and pulse are registered together so they are seen in DONE.
                state_q     <= DONE;
                crc_out_q   <= crc_fin;
                crc_valid_q <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          DONE: begin
            crc_q   <= INIT;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crc8_serial.sv
// Self-checking bench for crc8_serial: random and known-vector messages against a byte-wise CRC model.
module tb_crc8_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       crc_valid;
  logic [7:0] crc_out;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] msg[$];
  logic [7:0] pulse_q[$];
  int         pulse_cyc_q[$];

`ifdef CRC8_SERIAL_XOROUT_EN
  localparam logic [7:0] XO = 8'hFF;
`else
  localparam logic [7:0] XO = 8'h00;
`endif

  crc8_serial #(.POLY(8'h07), .INIT(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .crc_valid(crc_valid), .crc_out(crc_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (crc_valid === 1'b1) begin
      pulse_q.push_back(crc_out);
      pulse_cyc_q.push_back(cyc);
    end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // Classic byte-wise CRC-8: fold the byte into the top, then 8 polynomial divisions.
  function automatic logic [7:0] model_crc();
    logic [7:0] c;
    c = 8'h00;
    foreach (msg[i]) begin
      c = c ^ msg[i];
      for (int b = 0; b < 8; b++)
        c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c ^ XO;
  endfunction

  // Entered and left on a falling edge; t_acc is the cycle the byte was accepted in.
  task automatic send_byte(input logic [7:0] d, input logic l, output int t_acc);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      failures++;
      $display("FAIL ready_timeout in_ready=%b required 1 within 40 cycles", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    t_acc    = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic send_msg();
    int t, tprev, n0;
    logic [7:0] exp;
    exp = model_crc();
    n0  = pulse_q.size();
    t = 0;
    tprev = 0;
    foreach (msg[i]) begin
      send_byte(msg[i], (i == msg.size() - 1), t);
      if (i > 0) begin
        checks++;
        if (t - tprev != 9) begin
          failures++;
          $display("FAIL byte_interval got %0d required 9", t - tprev);
        end
      end
      tprev = t;
    end
    while (cyc <= t + 8) begin
      checks++;
      if (crc_valid !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL shift_phase cyc=T+%0d crc_valid=%b busy=%b required 0/1", cyc - t, crc_valid, busy);
      end
      @(negedge clk);
    end
    checks++;
    if (crc_valid !== 1'b1 || crc_out !== exp || busy !== 1'b1) begin
      failures++;
      $display("FAIL done_T+9 crc_valid=%b crc_out=%h busy=%b required 1/%h/1", crc_valid, crc_out, busy, exp);
    end
    @(negedge clk);
    checks++;
    if (crc_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || crc_out !== exp) begin
      failures++;
      $display("FAIL idle_T+10 crc_valid=%b in_ready=%b busy=%b crc_out=%h required 0/1/0/%h",
               crc_valid, in_ready, busy, crc_out, exp);
    end
    checks++;
    if (pulse_q.size() != n0 + 1) begin
      failures++;
      $display("FAIL pulse_count got %0d required %0d", pulse_q.size() - n0, 1);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (crc_out !== 8'h00 || crc_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs crc_out=%h crc_valid=%b busy=%b in_ready=%b required 00/0/0/1",
               crc_out, crc_valid, busy, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    msg = {8'h01};
    send_msg();
    checks++;
    if (crc_out !== (8'h07 ^ XO)) begin
      failures++;
      $display("FAIL single_01 crc_out=%h required %h", crc_out, 8'h07 ^ XO);
    end
  endtask

  task automatic test_check_string();
    msg = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_msg();
    checks++;
    if (crc_out !== (8'hF4 ^ XO)) begin
      failures++;
      $display("FAIL check_123456789 crc_out=%h required %h", crc_out, 8'hF4 ^ XO);
    end
  endtask

  task automatic test_init_reload();
    msg = {8'hFF};
    send_msg();
    checks++;
    if (crc_out !== (8'hF3 ^ XO)) begin
      failures++;
      $display("FAIL single_FF crc_out=%h required %h", crc_out, 8'hF3 ^ XO);
    end
    msg = {8'h00};
    send_msg();
    checks++;
    if (crc_out !== (8'h00 ^ XO)) begin
      failures++;
      $display("FAIL single_00_after_FF crc_out=%h required %h", crc_out, 8'h00 ^ XO);
    end
  endtask

  task automatic test_random();
    for (int m = 0; m < 8; m++) begin
      msg.delete();
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) msg.push_back(8'($urandom));
      send_msg();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[4];
    int acc_t[$];
    int idx, n0;
    logic [7:0] e0, e1;
    foreach (b[i]) b[i] = 8'($urandom);
    n0  = pulse_q.size();
    idx = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 60 && idx < 4; k++) begin
      checks++;
      if (in_ready !== !busy) begin
        failures++;
        $display("FAIL b2b_ready_vs_busy in_ready=%b required %b", in_ready, !busy);
      end
      if (in_ready === 1'b1) begin
        in_data = b[idx];
        in_last = (idx == 1 || idx == 3);
        acc_t.push_back(cyc);
        idx++;
      end else begin
        in_data = 8'($urandom);
        in_last = 1'($urandom);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 4) begin
      failures++;
      $display("FAIL b2b_accepts got %0d required 4", idx);
    end else begin
      checks++;
      if (acc_t[1] - acc_t[0] != 9 || acc_t[2] - acc_t[1] != 10 || acc_t[3] - acc_t[2] != 9) begin
        failures++;
        $display("FAIL b2b_spacing got %0d,%0d,%0d required 9,10,9",
                 acc_t[1] - acc_t[0], acc_t[2] - acc_t[1], acc_t[3] - acc_t[2]);
      end
      while (cyc <= acc_t[3] + 10) @(negedge clk);
      msg = {b[0], b[1]};
      e0 = model_crc();
      msg = {b[2], b[3]};
      e1 = model_crc();
      checks++;
      if (pulse_q.size() != n0 + 2) begin
        failures++;
        $display("FAIL b2b_pulses got %0d required 2", pulse_q.size() - n0);
      end else begin
        checks++;
        if (pulse_q[n0] !== e0 || pulse_q[n0+1] !== e1 || pulse_cyc_q[n0] != acc_t[1] + 9) begin
          failures++;
          $display("FAIL b2b_results got %h,%h@%0d required %h,%h@%0d",
                   pulse_q[n0], pulse_q[n0+1], pulse_cyc_q[n0], e0, e1, acc_t[1] + 9);
        end
      end
    end
  endtask

  task automatic test_clear();
    int t, n0;
    logic [7:0] prev;
    send_byte(8'h31, 1'b0, t);
    send_byte(8'h32, 1'b0, t);
    send_byte(8'h33, 1'b0, t);
    repeat (2) @(negedge clk);
    prev = crc_out;
    n0   = pulse_q.size();
    clear = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    in_last  = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_ready_shift in_ready=%b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || crc_out !== prev) begin
      failures++;
      $display("FAIL clear_abort busy=%b in_ready=%b crc_out=%h required 0/1/%h", busy, in_ready, crc_out, prev);
    end
    // Clear in IDLE must also block an offered byte.
    clear = 1'b1;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_ready_idle in_ready=%b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pulse_q.size() != n0 || crc_out !== prev) begin
      failures++;
      $display("FAIL clear_no_pulse busy=%b pulses=%0d crc_out=%h required 0/0/%h",
               busy, pulse_q.size() - n0, crc_out, prev);
    end
    msg = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_msg();
    checks++;
    if (crc_out !== (8'hF4 ^ XO)) begin
      failures++;
      $display("FAIL clear_resend crc_out=%h required %h", crc_out, 8'hF4 ^ XO);
    end
  endtask

  task automatic test_async_reset();
    int t, n0;
    n0 = pulse_q.size();
    send_byte(8'($urandom), 1'b0, t);
    send_byte(8'($urandom), 1'b0, t);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || crc_out !== 8'h00 || crc_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset busy=%b crc_out=%h crc_valid=%b in_ready=%b required 0/00/0/1",
               busy, crc_out, crc_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (pulse_q.size() != n0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_no_pulse pulses=%0d busy=%b required 0/0", pulse_q.size() - n0, busy);
    end
    msg.delete();
    for (int k = 0; k < 3; k++) msg.push_back(8'($urandom));
    send_msg();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_check_string();
    test_init_reload();
    test_random();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
